// File: rtl/dsp48a1_slice.sv
// DSP48A1-style arithmetic slice: 18-bit pre-adder, 18x18 unsigned multiplier
// and 48-bit post-adder, each stage individually registered or bypassed.
module dsp48a1_slice #(
  parameter int unsigned A0REG       = 0,
  parameter int unsigned A1REG       = 1,
  parameter int unsigned B0REG       = 0,
  parameter int unsigned B1REG       = 1,
  parameter int unsigned CREG        = 1,
  parameter int unsigned DREG        = 1,
  parameter int unsigned MREG        = 1,
  parameter int unsigned PREG        = 1,
  parameter int unsigned CARRYINREG  = 1,
  parameter int unsigned CARRYOUTREG = 1,
  parameter int unsigned OPMODEREG   = 1,
  parameter string       CARRYINSEL  = "OPMODE5",
  parameter string       B_INPUT     = "DIRECT",
  parameter string       RSTTYPE     = "ASYNC"
) (
  input  logic [17:0] A,
  input  logic [17:0] B,
  input  logic [17:0] D,
  input  logic [47:0] C,
  input  logic        CLK,
  input  logic        CARRYIN,
  input  logic [7:0]  OPMODE,
  input  logic [17:0] BCIN,
  input  logic        RSTA,
  input  logic        RSTB,
  input  logic        RSTM,
  input  logic        RSTP,
  input  logic        RSTC,
  input  logic        RSTD,
  input  logic        RSTCARRYIN,
  input  logic        RSTOPMODE,
  input  logic        CEA,
  input  logic        CEB,
  input  logic        CEM,
  input  logic        CEP,
  input  logic        CEC,
  input  logic        CED,
  input  logic        CECARRYIN,
  input  logic        CEOPMODE,
  input  logic [47:0] PCIN,
  output logic [17:0] BCOUT,
  output logic [47:0] PCOUT,
  output logic [47:0] P,
  output logic [35:0] M,
  output logic        CARRYOUT,
  output logic        CARRYOUTF
);

  // Resets are always asynchronous; the reset-type parameter has no effect.
  if (RSTTYPE == "") begin : g_rsttype_ignored
  end

  logic [17:0] b_sel, b0, b0_r, a0, a0_r, a1, a1_r, d, d_r, pre, b1, b1_r;
  logic [47:0] c, c_r, x, z, p, p_r;
  logic [35:0] mult, m, m_r;
  logic [7:0]  opm, opm_r;
  logic        cyi_sel, cin, cyi_r, co_r;
  logic [48:0] post;

  assign b_sel = (B_INPUT == "DIRECT")  ? B    :
                 (B_INPUT == "CASCADE") ? BCIN : '0;

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      b0_r <= '0;
      b1_r <= '0;
    end else if (CEB) begin
      b0_r <= b_sel;
      b1_r <= pre;
    end
  end

  always_ff @(posedge CLK or negedge RSTA) begin
    if (!RSTA) begin
      a0_r <= '0;
      a1_r <= '0;
    end else if (CEA) begin
      a0_r <= A;
      a1_r <= a0;
    end
  end

  always_ff @(posedge CLK or negedge RSTC) begin
    if (!RSTC)    c_r <= '0;
    else if (CEC) c_r <= C;
  end

  always_ff @(posedge CLK or negedge RSTD) begin
    if (!RSTD)    d_r <= '0;
    else if (CED) d_r <= D;
  end

  always_ff @(posedge CLK or negedge RSTOPMODE) begin
    if (!RSTOPMODE)    opm_r <= '0;
    else if (CEOPMODE) opm_r <= OPMODE;
  end

  always_ff @(posedge CLK or negedge RSTM) begin
    if (!RSTM)    m_r <= '0;
    else if (CEM) m_r <= mult;
  end

  always_ff @(posedge CLK or negedge RSTCARRYIN) begin
    if (!RSTCARRYIN)    cyi_r <= 1'b0;
    else if (CECARRYIN) cyi_r <= cyi_sel;
  end

  always_ff @(posedge CLK or negedge RSTP) begin
    if (!RSTP) begin
      p_r  <= '0;
      co_r <= 1'b0;
    end else if (CEP) begin
      p_r  <= post[47:0];
      co_r <= post[48];
    end
  end

  assign b0  = (B0REG != 0)     ? b0_r  : b_sel;
  assign a0  = (A0REG != 0)     ? a0_r  : A;
  assign a1  = (A1REG != 0)     ? a1_r  : a0;
  assign c   = (CREG != 0)      ? c_r   : C;
  assign d   = (DREG != 0)      ? d_r   : D;
  assign opm = (OPMODEREG != 0) ? opm_r : OPMODE;

  assign pre  = opm[4] ? (opm[6] ? d - b0 : d + b0) : b0;
  assign b1   = (B1REG != 0) ? b1_r : pre;
  assign mult = 36'(a1) * 36'(b1);
  assign m    = (MREG != 0) ? m_r : mult;

  assign cyi_sel = (CARRYINSEL == "OPMODE5") ? opm[5]  :
                   (CARRYINSEL == "CARRYIN") ? CARRYIN : 1'b0;
  assign cin     = (CARRYINREG != 0) ? cyi_r : cyi_sel;

  always_comb begin
    x = '0;
    case (opm[1:0])
      2'd0: x = '0;
      2'd1: x = {12'd0, m};
      2'd2: x = p;
      2'd3: x = {d[11:0], a1, b1};
    endcase
    z = '0;
    case (opm[3:2])
      2'd0: z = '0;
      2'd1: z = PCIN;
      2'd2: z = p;
      2'd3: z = c;
    endcase
  end

  // 49-bit arithmetic: bit 48 is the carry on add and the borrow on subtract.
  assign post = opm[7] ? {1'b0, z} - ({1'b0, x} + 49'(cin))
                       : {1'b0, z} + {1'b0, x} + 49'(cin);

  assign p         = (PREG != 0) ? p_r : post[47:0];
  assign P         = p;
  assign PCOUT     = p;
  assign M         = m;
  assign BCOUT     = b1;
  assign CARRYOUT  = (CARRYOUTREG != 0) ? co_r : post[48];
  assign CARRYOUTF = CARRYOUT;

endmodule

// File: tb/tb_dsp48a1_slice.sv
// Scoreboard bench for dsp48a1_slice in its default (all-registered) configuration.
module tb_dsp48a1_slice;

  logic [17:0] A, B, D, BCIN;
  logic [47:0] C, PCIN;
  logic        CLK, CARRYIN;
  logic [7:0]  OPMODE;
  logic        RSTA, RSTB, RSTM, RSTP, RSTC, RSTD, RSTCARRYIN, RSTOPMODE;
  logic        CEA, CEB, CEM, CEP, CEC, CED, CECARRYIN, CEOPMODE;
  logic [17:0] BCOUT;
  logic [47:0] PCOUT, P;
  logic [35:0] M;
  logic        CARRYOUT, CARRYOUTF;

  int unsigned compared = 0;
  int unsigned mismatched = 0;
  logic [47:0] exp_q[$];
  logic [47:0] exp_v;

  dsp48a1_slice dut (
    .A(A), .B(B), .D(D), .C(C), .CLK(CLK), .CARRYIN(CARRYIN), .OPMODE(OPMODE),
    .BCIN(BCIN), .RSTA(RSTA), .RSTB(RSTB), .RSTM(RSTM), .RSTP(RSTP), .RSTC(RSTC),
    .RSTD(RSTD), .RSTCARRYIN(RSTCARRYIN), .RSTOPMODE(RSTOPMODE), .CEA(CEA),
    .CEB(CEB), .CEM(CEM), .CEP(CEP), .CEC(CEC), .CED(CED), .CECARRYIN(CECARRYIN),
    .CEOPMODE(CEOPMODE), .PCIN(PCIN), .BCOUT(BCOUT), .PCOUT(PCOUT), .P(P), .M(M),
    .CARRYOUT(CARRYOUT), .CARRYOUTF(CARRYOUTF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic test_reset();
    {RSTA, RSTB, RSTM, RSTP, RSTC, RSTD, RSTCARRYIN, RSTOPMODE} = '0;
    {CEA, CEB, CEM, CEP, CEC, CED, CECARRYIN, CEOPMODE} = '1;
    A = 18'h2A5A5; B = 18'h1F0F0; D = 18'h3C3C3; BCIN = 18'h12345;
    C = 48'hDEAD_BEEF_1234; PCIN = 48'h1111_2222_3333; CARRYIN = 1'b1; OPMODE = 8'hFF;
    cycles(3);
    exp_q.push_back('0); exp_q.push_back('0); exp_q.push_back('0);
    exp_q.push_back('0); exp_q.push_back('0); exp_q.push_back('0);
    exp_v = exp_q.pop_front(); compared++;
    if (P !== exp_v) begin $display("FAIL reset_p: got %h want %h", P, exp_v); mismatched++; end
    exp_v = exp_q.pop_front(); compared++;
    if (48'(M) !== exp_v) begin $display("FAIL reset_m: got %h want %h", M, exp_v); mismatched++; end
    exp_v = exp_q.pop_front(); compared++;
    if (48'(BCOUT) !== exp_v) begin $display("FAIL reset_bcout: got %h want %h", BCOUT, exp_v); mismatched++; end
    exp_v = exp_q.pop_front(); compared++;
    if (PCOUT !== exp_v) begin $display("FAIL reset_pcout: got %h want %h", PCOUT, exp_v); mismatched++; end
    exp_v = exp_q.pop_front(); compared++;
    if (48'(CARRYOUT) !== exp_v) begin $display("FAIL reset_carryout: got %h want %h", CARRYOUT, exp_v); mismatched++; end
    exp_v = exp_q.pop_front(); compared++;
    if (48'(CARRYOUTF) !== exp_v) begin $display("FAIL reset_carryoutf: got %h want %h", CARRYOUTF, exp_v); mismatched++; end
    {RSTA, RSTB, RSTM, RSTP, RSTC, RSTD, RSTCARRYIN, RSTOPMODE} = '1;
  endtask

  // Checks the exact latency from A/B to M (2 edges) and to P (3 edges).
  task automatic test_mult_add();
    A = 18'd2; B = 18'd5; C = 48'd4; D = 18'd0; OPMODE = 8'h0D;
    exp_q.push_back(48'd10); exp_q.push_back(48'd14);
    cycles(2);
    exp_v = exp_q.pop_front(); compared++;
    if (48'(M) !== exp_v) begin $display("FAIL mult_m_latency: got %h want %h", M, exp_v); mismatched++; end
    cycles(1);
    exp_v = exp_q.pop_front(); compared++;
    if (P !== exp_v) begin $display("FAIL mult_p_latency: got %h want %h", P, exp_v); mismatched++; end
    exp_q.push_back(48'd14);
    cycles(2);
    exp_v = exp_q.pop_front(); compared++;
    if (P !== exp_v) begin $display("FAIL mult_p_steady: got %h want %h", P, exp_v); mismatched++; end
  endtask

  task automatic clear_p();
    RSTP = 1'b0;
    cycles(1);
    RSTP = 1'b1;
  endtask

  task automatic test_accumulate_carry();
    A = 18'd2; B = 18'd5; D = 18'd3; OPMODE = 8'h32;
    cycles(5);
    clear_p();
    for (int k = 1; k <= 5; k++) exp_q.push_back(48'(k));
    for (int k = 1; k <= 5; k++) begin
      cycles(1);
      exp_v = exp_q.pop_front(); compared++;
      if (P !== exp_v) begin $display("FAIL acc_carry_p%0d: got %h want %h", k, P, exp_v); mismatched++; end
    end
    exp_q.push_back(48'd8); exp_q.push_back(48'd16);
    exp_v = exp_q.pop_front(); compared++;
    if (48'(BCOUT) !== exp_v) begin $display("FAIL acc_carry_bcout: got %h want %h", BCOUT, exp_v); mismatched++; end
    exp_v = exp_q.pop_front(); compared++;
    if (48'(M) !== exp_v) begin $display("FAIL acc_carry_m: got %h want %h", M, exp_v); mismatched++; end
  endtask

  task automatic test_mac();
    A = 18'd5; B = 18'd9; D = 18'd4; OPMODE = 8'h39;
    cycles(5);
    clear_p();
    for (int k = 1; k <= 4; k++) exp_q.push_back(48'(66 * k));
    for (int k = 1; k <= 4; k++) begin
      cycles(1);
      exp_v = exp_q.pop_front(); compared++;
      if (P !== exp_v) begin $display("FAIL mac_p%0d: got %h want %h", k, P, exp_v); mismatched++; end
      compared++;
      if (PCOUT !== exp_v) begin $display("FAIL mac_pcout%0d: got %h want %h", k, PCOUT, exp_v); mismatched++; end
    end
    exp_q.push_back(48'd13); exp_q.push_back(48'd65);
    exp_v = exp_q.pop_front(); compared++;
    if (48'(BCOUT) !== exp_v) begin $display("FAIL mac_bcout: got %h want %h", BCOUT, exp_v); mismatched++; end
    exp_v = exp_q.pop_front(); compared++;
    if (48'(M) !== exp_v) begin $display("FAIL mac_m: got %h want %h", M, exp_v); mismatched++; end
  endtask

  task automatic test_subtract();
    A = 18'd3; B = 18'd5; C = 48'd100; D = 18'd0; OPMODE = 8'h8D;
    cycles(4);
    exp_q.push_back(48'd85); exp_q.push_back(48'd0);
    exp_v = exp_q.pop_front(); compared++;
    if (P !== exp_v) begin $display("FAIL sub_p: got %h want %h", P, exp_v); mismatched++; end
    exp_v = exp_q.pop_front(); compared++;
    if (48'(CARRYOUT) !== exp_v) begin $display("FAIL sub_carryout: got %h want %h", CARRYOUT, exp_v); mismatched++; end
    C = 48'd0;
    cycles(2);
    exp_q.push_back(48'hFFFF_FFFF_FFF1); exp_q.push_back(48'd1); exp_q.push_back(48'd1);
    exp_v = exp_q.pop_front(); compared++;
    if (P !== exp_v) begin $display("FAIL sub_borrow_p: got %h want %h", P, exp_v); mismatched++; end
    exp_v = exp_q.pop_front(); compared++;
    if (48'(CARRYOUT) !== exp_v) begin $display("FAIL sub_borrow_co: got %h want %h", CARRYOUT, exp_v); mismatched++; end
    exp_v = exp_q.pop_front(); compared++;
    if (48'(CARRYOUTF) !== exp_v) begin $display("FAIL sub_borrow_cof: got %h want %h", CARRYOUTF, exp_v); mismatched++; end
  endtask

  // Pre-adder subtract wraps modulo 2^18: 3 - 5 = 0x3FFFE.
  task automatic test_preadd_wrap();
    A = 18'd1; B = 18'd5; D = 18'd3; C = 48'd0; OPMODE = 8'h51;
    cycles(6);
    exp_q.push_back(48'h3FFFE); exp_q.push_back(48'h3FFFE); exp_q.push_back(48'h3FFFE);
    exp_v = exp_q.pop_front(); compared++;
    if (48'(BCOUT) !== exp_v) begin $display("FAIL prewrap_bcout: got %h want %h", BCOUT, exp_v); mismatched++; end
    exp_v = exp_q.pop_front(); compared++;
    if (48'(M) !== exp_v) begin $display("FAIL prewrap_m: got %h want %h", M, exp_v); mismatched++; end
    exp_v = exp_q.pop_front(); compared++;
    if (P !== exp_v) begin $display("FAIL prewrap_p: got %h want %h", P, exp_v); mismatched++; end
  endtask

  task automatic test_hold_and_reset();
    A = 18'd2; B = 18'd5; C = 48'd4; D = 18'd0; OPMODE = 8'h0D;
    cycles(5);
    CEP = 1'b0; A = 18'd7; C = 48'd1000;
    cycles(4);
    exp_q.push_back(48'd14);
    exp_v = exp_q.pop_front(); compared++;
    if (P !== exp_v) begin $display("FAIL hold_p: got %h want %h", P, exp_v); mismatched++; end
    #2 RSTP = 1'b0;
    #1;
    exp_q.push_back(48'd0);
    exp_v = exp_q.pop_front(); compared++;
    if (P !== exp_v) begin $display("FAIL async_rst_p: got %h want %h", P, exp_v); mismatched++; end
    @(negedge CLK);
    RSTP = 1'b1; CEP = 1'b1;
    cycles(1);
    exp_q.push_back(48'd1035);
    exp_v = exp_q.pop_front(); compared++;
    if (P !== exp_v) begin $display("FAIL resume_p: got %h want %h", P, exp_v); mismatched++; end
  endtask

  // New A/B pair every cycle; each product emerges on P three edges later.
  task automatic test_back_to_back();
    int n;
    n = 8;
    C = 48'd0; D = 18'd0; OPMODE = 8'h01;
    cycles(4);
    for (int t = 0; t < n + 3; t++) begin
      if (t >= 3) begin
        exp_v = exp_q.pop_front(); compared++;
        if (P !== exp_v) begin $display("FAIL b2b_p%0d: got %h want %h", t - 3, P, exp_v); mismatched++; end
      end
      if (t < n) begin
        A = 18'($urandom); B = 18'($urandom);
        exp_q.push_back(48'(36'(A) * 36'(B)));
      end
      @(negedge CLK);
    end
  endtask

  initial begin
    test_reset();
    test_mult_add();
    test_accumulate_carry();
    test_mac();
    test_subtract();
    test_preadd_wrap();
    test_hold_and_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dsp48a1_slice.md
Name: dsp48a1_slice

Overview:
Parameterised DSP slice modelled on the Spartan-6 DSP48A1. It has:
- an 18-bit pre-adder/subtracter;
- an 18x18 unsigned multiplier;
- a 48-bit post-adder/subtracter with X/Z operand multiplexers, carry-in/carry-out, and B/P cascade ports.

Every pipeline stage can be individually registered through parameters. Each register has its own clock enable and its own reset. The block is instantiated as a leaf arithmetic engine in filter and MAC datapaths.

Parameters:
- A0REG, 0: 1 = register A at stage 0, 0 = pass A straight through.
- A1REG, 1: register A at stage 1.
- B0REG, 0: register the selected B input at stage 0.
- B1REG, 1: register the pre-adder output at stage 1.
- CREG, 1: register C.
- DREG, 1: register D.
- MREG, 1: register the multiplier output.
- PREG, 1: register the post-adder output.
- CARRYINREG, 1: register the selected carry-in.
- CARRYOUTREG, 1: register the carry-out.
- OPMODEREG, 1: register OPMODE.
- CARRYINSEL, "OPMODE5": carry-in source.
  - "OPMODE5" = OPMODE[5].
  - "CARRYIN" = the CARRYIN port.
  - Any other value gives 0.
- B_INPUT, "DIRECT": B source.
  - "DIRECT" = the B port.
  - "CASCADE" = the BCIN port.
  - Any other value gives 0.
- RSTTYPE, "ASYNC": kept only for positional compatibility. It is ignored; resets are always asynchronous.

Ports:
- CLK, in, 1: the single clock; all registers update on the rising edge.
- RSTA, RSTB, RSTC, RSTD, RSTM, RSTP, RSTCARRYIN, RSTOPMODE, in, 1 each: asynchronous active-low resets, one per register group.
- A, in, 18: multiplier operand.
- B, in, 18: direct B operand.
- BCIN, in, 18: cascaded B operand.
- C, in, 48: post-adder operand.
- D, in, 18: pre-adder operand.
- CARRYIN, in, 1: external carry-in.
- OPMODE, in, 8: operation select.
- CEA, CEB, CEC, CED, CEM, CEP, CECARRYIN, CEOPMODE, in, 1 each: clock enables.
- PCIN, in, 48: cascaded P input.
- BCOUT, out, 18: the B1 stage value.
- PCOUT, out, 48: equal to P.
- P, out, 48: result.
- M, out, 36: multiplier result after the M stage.
- CARRYOUT, out, 1: post-adder carry.
- CARRYOUTF, out, 1: equal to CARRYOUT.

Positional port order:
A, B, D, C, CLK, CARRYIN, OPMODE, BCIN, RSTA, RSTB, RSTM, RSTP, RSTC, RSTD, RSTCARRYIN, RSTOPMODE, CEA, CEB, CEM, CEP, CEC, CED, CECARRYIN, CEOPMODE, PCIN, BCOUT, PCOUT, P, M, CARRYOUT, CARRYOUTF.

Behaviour:
Every stage is a register or a bypass, chosen by its parameter.
- When registered: the stage clears to 0 immediately while its reset is low. Reset dominates CE. The stage loads on the clock edge when CE=1 and holds when CE=0.
- When bypassed: the stage is combinational.
- Reset/CE mapping: A0 and A1 use RSTA/CEA; B0 and B1 use RSTB/CEB; C uses RSTC/CEC; D uses RSTD/CED; M uses RSTM/CEM; P and the carry-out register use RSTP/CEP; CYI uses RSTCARRYIN/CECARRYIN; OPMODE uses RSTOPMODE/CEOPMODE.
- All OPMODE bits below refer to the OPMODE stage output.

Datapath:
- B0 = stage(B_INPUT selection).
- Pre-adder:
  - OPMODE[4]=1: result is D+B0 when OPMODE[6]=0, and D−B0 when OPMODE[6]=1, truncated to 18 bits.
  - OPMODE[4]=0: result is B0.
- B1 = stage(pre-adder result). BCOUT = B1.
- A1 = stage(A0).
- M = stage(A1*B1), unsigned, 36 bits.
- X multiplexer, selected by OPMODE[1:0]:
  - 0 selects 0.
  - 1 selects M zero-extended to 48 bits.
  - 2 selects P.
  - 3 selects {D[11:0], A1, B1}.
- Z multiplexer, selected by OPMODE[3:2]:
  - 0 selects 0.
  - 1 selects PCIN.
  - 2 selects P.
  - 3 selects C (after the C stage).
- CIN = stage(carry-in selection, via CYI).
- Post-adder, computed in 49 bits:
  - OPMODE[7]=0: Z + X + CIN.
  - OPMODE[7]=1: Z − (X + CIN).
  - Bits [47:0] go to the P stage.
  - Bit 48 goes to the carry-out stage. On subtraction, bit 48 is 1 on borrow.
- P wraps modulo 2^48.

Timing with defaults:
- A, B, C, D, OPMODE, carry: one register each ahead of the multiplier or post-adder.
- A/B to M: 2 cycles.
- A/B to P: 3 cycles.
- D through the pre-adder to P: 4 cycles.
- C to P: 2 cycles.

Power-up and reset:
- All-registered configuration with all resets low: every output is 0.
- Releasing a reset mid-operation resumes from the cleared stage.

Test Plan:
1. All resets low, arbitrary inputs, all CE=1 → P, M, BCOUT, PCOUT, CARRYOUT all 0.
2. Release resets, CE=1, A=2, B=5, C=4, OPMODE=0x0D → M=10, and P=14 in steady state.
3. A=2, B=5, D=3, OPMODE=0x32 → BCOUT=8, M=16; P increments by 1 every cycle (accumulating the carry).
4. A=5, B=9, D=4, OPMODE=0x39 → BCOUT=13, M=65; P grows by 66 per cycle; PCOUT=P.
5. A=3, B=5, C=100, OPMODE=0x8D → P=85. With C=0, P=0xFFFFFFFFFFF1 and CARRYOUT=1 (borrow).
6. Steady computation, then CEP=0 while changing inputs → P holds. Pull RSTP low between clock edges → P clears immediately.
